sigmoid_pwl_pipe: RTL and testbench

- Parametrised successor to the single-bit threshold sigmoid activation used after the neuron accumulators.
- Computes a signed fixed-point sigmoid over a 3-stage pipeline, selectable per sample between:
  - legacy hard step;
  - PLAN piecewise-linear approximation (shift-add only, no multipliers).
- Uses a valid/ready handshake on both sides, so it can stall behind a slow consumer. It sits between the MAC/accumulator stage and the next-layer input buffer.

---
 rtl/sigmoid_pwl_pipe.sv | 91 +++++++++
 tb/tb_sigmoid_pwl_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pwl_pipe.sv
// Sigmoid on a signed Q(DW-FW).FW activation: legacy hard step or shift-add piecewise-linear (PLAN), chosen per sample.
// Latency: 3 cycles from input transfer to sig_ready. Throughput: 1 sample/cycle.
// Backpressure: all stages hold while sig_ready & !out_ack, and in_ready is low in that case.
module sigmoid_pwl_pipe #(
    parameter int DW = 16,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done,
    input  logic [DW-1:0] sig_in,
    input  logic          mode,
    output logic          in_ready,
    output logic          sig_ready,
    output logic [DW-1:0] sig_out,
    input  logic          out_ack
);

    localparam logic [DW-1:0] ONE     = DW'(1) << FW;
    localparam logic [DW-1:0] HALF    = DW'(1) << (FW - 1);
    localparam logic [DW-1:0] C_625   = DW'(5) << (FW - 3);
    localparam logic [DW-1:0] C_84375 = DW'((27 << FW) >> 5);
    localparam logic [DW-1:0] BP_2375 = DW'(19) << (FW - 3);
    localparam logic [DW-1:0] BP_5    = DW'(5) << FW;
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef struct packed {
        logic          vld;
        logic          neg;
        logic          pln;
        logic [DW-1:0] val;
    } stage_t;

    stage_t        s1;
    stage_t        s2;
    logic          en;
    logic [DW-1:0] abs_in;
    logic [DW-1:0] y;
    logic [DW-1:0] res;

    // Bubbles advance with the pipe, so one enable covers every stage.
    assign en       = !sig_ready || out_ack;
    assign in_ready = en;

    // The most-negative input has no positive counterpart; clamp its magnitude.
    always_comb begin
        abs_in = sig_in;
        if (sig_in[DW-1]) begin
            abs_in = (sig_in == MIN_NEG) ? MAX_POS : (~sig_in + DW'(1));
        end
    end

    always_comb begin
        y = ONE;
        if (s1.val < ONE) begin
            y = (s1.val >> 2) + HALF;
        end else if (s1.val < BP_2375) begin
            y = (s1.val >> 3) + C_625;
        end else if (s1.val < BP_5) begin
            y = (s1.val >> 5) + C_84375;
        end
    end

    // Bubbles drive zero so a stale value can never sit on sig_out.
    always_comb begin
        res = '0;
        if (s2.vld) begin
            if (s2.pln) begin
                res = s2.neg ? (ONE - s2.val) : s2.val;
            end else begin
                res = s2.neg ? '0 : ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            sig_ready <= 1'b0;
            sig_out   <= '0;
        end else if (en) begin
            s1        <= '{vld: done, neg: sig_in[DW-1], pln: mode, val: abs_in};
            s2        <= '{vld: s1.vld, neg: s1.neg, pln: s1.pln, val: y};
            sig_ready <= s2.vld;
            sig_out   <= res;
        end
    end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Directed bench for sigmoid_pwl_pipe (DW=16, FW=8) with hand-computed expected results.
module tb_sigmoid_pwl_pipe;

    localparam int DW = 16;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          done;
    logic [DW-1:0] sig_in;
    logic          mode;
    logic          in_ready;
    logic          sig_ready;
    logic [DW-1:0] sig_out;
    logic          out_ack;

    int errors = 0;
    int checks = 0;
    int win = 0;

    logic [15:0] exp_q[$];
    int          win_q[$];
    logic [15:0] cur_exp;
    bit          lat_chk;
    bit          prev_hold;
    logic [15:0] prev_out;
    bit          tp_on;
    int          first_win;
    int          last_out_win;
    int          gaps;

    logic [15:0] pv_in  [11] = '{16'h0000, 16'h0080, 16'h0100, 16'hFF00, 16'h0300, 16'h0600,
                                 16'h8000, 16'h00FF, 16'h0260, 16'h04FF, 16'h0500};
    logic [15:0] pv_exp [11] = '{16'h0080, 16'h00A0, 16'h00C0, 16'h0040, 16'h00F0, 16'h0100,
                                 16'h0000, 16'h00BF, 16'h00EB, 16'h00FF, 16'h0100};
    logic [15:0] sv_in  [4]  = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
    logic [15:0] sv_exp [4]  = '{16'h0100, 16'h0100, 16'h0000, 16'h0000};
    logic [15:0] al_in  [6]  = '{16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'h0300, 16'h0300};
    logic        al_mode[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] al_exp [6]  = '{16'h0100, 16'h00C0, 16'h0000, 16'h0040, 16'h0100, 16'h00F0};

    always #5 clk = ~clk;

    sigmoid_pwl_pipe #(.DW(DW), .FW(FW)) dut (
        .clk      (clk),
        .reset    (reset),
        .done     (done),
        .sig_in   (sig_in),
        .mode     (mode),
        .in_ready (in_ready),
        .sig_ready(sig_ready),
        .sig_out  (sig_out),
        .out_ack  (out_ack)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] d, input logic m, input logic [15:0] e);
        done    = 1'b1;
        sig_in  = d;
        mode    = m;
        cur_exp = e;
    endtask

    // One clock window: called just after a rising edge, returns just after the next one.
    task automatic cycle(input string tag, output bit in_x);
        logic [15:0] e;
        int          w;
        bit          out_x;
        #1;
        in_x  = done && in_ready;
        out_x = sig_ready && out_ack;
        if (prev_hold) begin
            check({tag, ":hold_vld"}, {15'b0, sig_ready}, 16'd1);
            check({tag, ":hold_dat"}, sig_out, prev_out);
        end
        check({tag, ":in_ready"}, {15'b0, in_ready}, {15'b0, !(sig_ready && !out_ack)});
        if (tp_on && win >= first_win + 3 && win <= first_win + 102 && !sig_ready) gaps++;
        if (out_x) begin
            if (exp_q.size() == 0) begin
                check({tag, ":spurious"}, {15'b0, sig_ready}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                w = win_q.pop_front();
                check({tag, ":data"}, sig_out, e);
                if (lat_chk) check({tag, ":latency"}, 16'(win - w), 16'd3);
                last_out_win = win;
            end
        end
        if (in_x) begin
            exp_q.push_back(cur_exp);
            win_q.push_back(win);
        end
        prev_hold = sig_ready && !out_ack;
        prev_out  = sig_out;
        @(posedge clk);
        win++;
        #1;
    endtask

    task automatic drain(input string tag);
        bit x;
        done = 1'b0;
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) cycle(tag, x);
        check({tag, ":drain"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit x;
        int idx;
        reset = 1'b0; done = 1'b0; sig_in = '0; mode = 1'b0; out_ack = 1'b1;
        lat_chk = 1'b0; prev_hold = 1'b0; tp_on = 1'b0; gaps = 0;
        cur_exp = '0; prev_out = '0; first_win = 0; last_out_win = 0;

        #1;
        check("reset:sig_ready", {15'b0, sig_ready}, 16'd0);
        check("reset:sig_out", sig_out, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset:in_ready", {15'b0, in_ready}, 16'd1);

        // PLAN values and breakpoints, back to back.
        lat_chk = 1'b1;
        for (int i = 0; i < 11; i++) begin
            put(pv_in[i], 1'b1, pv_exp[i]);
            cycle("plan", x);
        end
        drain("plan");

        for (int i = 0; i < 4; i++) begin
            put(sv_in[i], 1'b0, sv_exp[i]);
            cycle("step", x);
        end
        drain("step");

        for (int i = 0; i < 6; i++) begin
            put(al_in[i], al_mode[i], al_exp[i]);
            cycle("alt", x);
        end
        drain("alt");

        // Random backpressure; the source holds each sample until taken.
        lat_chk = 1'b0;
        idx = 0;
        for (int n = 0; n < 300 && (idx < 8 || exp_q.size() > 0); n++) begin
            out_ack = 1'($urandom_range(0, 1));
            if (idx < 8) put(pv_in[idx], 1'b1, pv_exp[idx]);
            else done = 1'b0;
            cycle("bp", x);
            if (x) idx++;
        end
        check("bp:count", 16'(idx), 16'd8);
        out_ack = 1'b1;
        drain("bp");

        // Fill the pipe while stalled, then reset with three samples in flight.
        out_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(pv_in[i + 3], 1'b1, pv_exp[i + 3]);
            cycle("rst_fill", x);
        end
        check("rst_fill:full", {15'b0, sig_ready}, 16'd1);
        done = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid:sig_ready", {15'b0, sig_ready}, 16'd0);
        check("rst_mid:sig_out", sig_out, 16'h0000);
        exp_q.delete();
        win_q.delete();
        prev_hold = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ack = 1'b1;
        for (int i = 0; i < 4; i++) cycle("rst_idle", x);
        lat_chk = 1'b1;
        put(16'h0100, 1'b1, 16'h00C0);
        cycle("rst_new", x);
        drain("rst_new");

        // 100 back-to-back samples at full rate.
        tp_on = 1'b1;
        first_win = win;
        for (int i = 0; i < 100; i++) begin
            put(pv_in[i % 11], 1'b1, pv_exp[i % 11]);
            cycle("tput", x);
        end
        drain("tput");
        tp_on = 1'b0;
        check("tput:cycles", 16'(last_out_win - first_win + 1), 16'd103);
        check("tput:gaps", 16'(gaps), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
